ex_muldiv_sequencer: RTL and testbench
======================================

Name: ex_muldiv_sequencer

Overview:
- Multi-cycle controller for RV32M multiply/divide operations issued from the EX stage.
- Latches EX operands and runs an iterative shift-add multiplier or restoring divider, one bit per cycle.
- Holds the pipeline through the hazard unit via `stall`, then presents a single-cycle `done` with the 32-bit result for the EX→MEM register.
- Handles RISC-V divide-by-zero and signed-overflow cases on a short fast path.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported. Iteration counter width is $clog2(XLEN)+1.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  valid M-extension op present in EX; held stable by the pipeline while `stall`=1
- op  input  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- a  input  32  rs1 operand, already forwarded
- b  input  32  rs2 operand, already forwarded
- flush  input  1  kill the current EX instruction (taken branch/jump squash)
- stall  output  1  freeze IF/ID/EX (combinational)
- done  output  1  result valid this cycle; pipeline advances on this cycle
- result  output  32  op result; valid when `done`=1

Behaviour:
- Reset (sync, `rst`=1 at a clk edge):
  - state←IDLE, counter←0, result←0, done←0.
  - Internal accumulator, quotient and remainder cleared.
  - Reset overrides all other inputs, including mid-RUN.
- States are IDLE, RUN and DONE.
- `stall` = (state==IDLE && start && !flush) || state==RUN. Deasserted in DONE.
- IDLE:
  - On `start`=1 and `flush`=0: latch op, sign flags, |a| and |b| (magnitudes per op signedness), clear counter.
  - Special case (div/rem with b==0, or DIV/REM with a==0x80000000 and b==0xFFFFFFFF): load the result directly and go to DONE.
  - Otherwise go to RUN.
- RUN:
  - One iteration per cycle; counter increments 0..31.
  - Multiply: 64-bit shift-add on magnitudes.
  - Divide: restoring; shift remainder left, subtract divisor, set quotient bit if the result is non-negative.
  - After the iteration with counter==31: apply sign correction, write `result`, go to DONE.
- DONE:
  - `done`=1 for exactly one cycle; `result` holds the final value.
  - Next state is IDLE unconditionally.
  - `start` is ignored in DONE; it still reflects the same instruction.
- Sign rules:
  - MUL returns low 32 bits. MULH/MULHSU/MULHU return high 32 bits.
  - Product is negated (64-bit two's complement) when operand signs differ; for MULHSU, b is treated as unsigned.
  - Quotient is negated if signs differ (DIV only).
  - Remainder takes the dividend's sign (REM only).
- Special results:
  - Divide by zero: DIV/DIVU = 0xFFFFFFFF; REM/REMU = a.
  - Signed overflow: DIV = 0x80000000; REM = 0.
- Latency, counted as EX occupancy from the first cycle `start` is seen in IDLE:
  - Normal ops: 34 cycles (1 IDLE + 32 RUN + 1 DONE); `stall` high for 33 cycles.
  - Special cases: 2 cycles; `stall` high for 1 cycle.
- Flush:
  - `flush`=1 in IDLE or RUN: state←IDLE at the next edge; `done` never asserts for that op; `result` keeps its previous value.
  - `flush` in DONE has no effect; `done` is already asserted and the state returns to IDLE.
  - `stall` drops combinationally during a flush cycle only if state==IDLE.
  - In RUN, `stall` remains asserted during the flush cycle and drops the next cycle.
- Back-to-back ops: a new `start` on the cycle after DONE (state IDLE) begins a fresh op; there is no bubble beyond the DONE→IDLE transition.
- `result` only changes when entering DONE.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3) → `stall` high for 33 cycles; `done` in cycle 34 with result=0xFFFFFFEB.
- MULH a=b=0x80000000 → result=0x40000000. MULHU a=b=0xFFFFFFFF → result=0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=2 → result=0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 → result=0xFFFFFFFD. REM with the same operands → result=0xFFFFFFFF. DIVU 100/7 → result=14. REMU 100/7 → result=2.
- DIVU a=5, b=0 → `done` at cycle 2, result=0xFFFFFFFF. REM a=5, b=0 → result=5. DIV 0x80000000/0xFFFFFFFF → result=0x80000000 at cycle 2. REM with the same operands → result=0.
- `flush` at RUN counter=10 → state IDLE next cycle, `stall` low, no `done` pulse, `result` unchanged. Separately, `rst` at counter=20 → all outputs 0 the following cycle.
- Back-to-back: MUL 3*4, then DIVU 9/3 starting the cycle after `done` → `done` pulses 34 cycles apart, results 12 then 3.

Source files
------------

// File: rtl/ex_muldiv_sequencer.sv
// ex_muldiv_sequencer: iterative RV32M multiply/divide unit for the EX stage.
// It runs one bit per cycle: a shift-add multiplier, or a restoring divider.
// The unit stalls the pipeline while it works, then pulses done for one cycle with the result.
// Divide-by-zero and signed overflow take a two-cycle fast path.
//
// Handshake: start is a level that the pipeline holds stable while stall=1.
// The op is accepted in IDLE when start=1 and flush=0.
// The pipeline advances on the single cycle where done=1.
// A flush in IDLE or RUN abandons the op and done never pulses for it.
module ex_muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    // Multiply: {partial high, multiplier}. Divide: {remainder, dividend/quotient}.
    logic [2*XLEN-1:0] acc_q, acc_d;
    // Holds the multiplicand for a multiply, or the divisor for a divide (magnitude).
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0]   a_mag, b_mag, spec_res;
    logic [XLEN:0]     mul_sum, div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem;
    logic [2*XLEN-1:0] mul_next, div_next, iter, prod_s;
    logic [XLEN-1:0]   quo, rem, fin;

    assign result = result_q;

    // Operand decode, one datapath iteration, final sign fix-up, and the FSM next state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        dvs_d    = dvs_q;
        result_d = result_q;
        stall    = 1'b0;
        done     = 1'b0;

        // a is signed for MULH/MULHSU/DIV/REM. b is signed for MULH/DIV/REM.
        // MUL uses magnitudes with no sign, because its low half does not depend on signedness.
        a_neg    = a[XLEN-1] & ((op == 3'd1) | (op == 3'd2) | (op == 3'd4) | (op == 3'd6));
        b_neg    = b[XLEN-1] & ((op == 3'd1) | (op == 3'd4) | (op == 3'd6));
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        div_zero = op[2] & (b == '0);
        div_ovf  = op[2] & ~op[0] & (a == SMIN) & (b == '1);
        if (div_zero) spec_res = op[1] ? a : '1;
        else          spec_res = op[1] ? '0 : SMIN;

        // Multiply step: add the multiplicand into the high half if the multiplier LSB is set, then shift right.
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};

        // Divide step: shift the next dividend bit into the remainder.
        // Keep the subtraction only if it does not go negative.
        div_shift = acc_q[2*XLEN-1:XLEN-1];
        div_ge    = div_shift >= {1'b0, dvs_q};
        div_rem   = div_ge ? (div_shift[XLEN-1:0] - dvs_q) : div_shift[XLEN-1:0];
        div_next  = {div_rem, acc_q[XLEN-2:0], div_ge};

        iter   = op_q[2] ? div_next : mul_next;
        prod_s = neg_q ? -iter : iter;
        quo    = neg_q ? -iter[XLEN-1:0] : iter[XLEN-1:0];
        rem    = neg_q ? -iter[2*XLEN-1:XLEN] : iter[2*XLEN-1:XLEN];
        case (op_q)
            3'd0:          fin = prod_s[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:          fin = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:    fin = quo;
            default:       fin = rem;
        endcase

        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    stall = 1'b1;
                    op_d  = op;
                    // REM follows the dividend's sign. Everything else follows the XOR of the two signs.
                    neg_d = (op[2] & op[1]) ? a_neg : (a_neg ^ b_neg);
                    acc_d = {{XLEN{1'b0}}, a_mag};
                    dvs_d = b_mag;
                    cnt_d = '0;
                    if (div_zero || div_ovf) begin
                        result_d = spec_res;
                        state_d  = DONE;
                    end else begin
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                stall = 1'b1;
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = iter;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(XLEN - 1)) begin
                        result_d = fin;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; synchronous reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            dvs_q    <= dvs_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Testbench for ex_muldiv_sequencer: directed RV32M vectors checked against an arithmetic model.
module tb_ex_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        stall, done;
    logic [31:0] result;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_result;
    logic        cmp_en;

    // Clock
    always #5 clk = ~clk;

    ex_muldiv_sequencer #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference arithmetic straight from the RV32M definitions.
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0]        xe, ye, p;
        logic signed [31:0] sx, sy, r;
        sx = x;
        sy = y;
        xe = (o == 3'd1 || o == 3'd2) ? {{32{x[31]}}, x} : {32'b0, x};
        ye = (o == 3'd1) ? {{32{y[31]}}, y} : {32'b0, y};
        p  = xe * ye;
        case (o)
            3'd0: return x * y;
            3'd1, 3'd2, 3'd3: return p[63:32];
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                r = sx / sy;
                return r;
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
                r = sx % sy;
                return r;
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic logic is_special(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        return o[2] && (y == 0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
    endfunction

    // Scoreboard: result must track the last completed op; every done pops one expectation.
    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            if (done) begin
                if (exp_q.size() == 0) chk("done_without_op", 32'(done), 32'd0);
                else exp_result = exp_q.pop_front();
            end
            chk("result_track", result, exp_result);
        end
    end

    // Issue one op and check stall/done every cycle plus the hand-computed result.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] lit, input string nm, input logic flush_at_done);
        logic [31:0] m;
        int          lat;
        m = model(o, x, y);
        chk({nm, "_model"}, m, lit);
        lat = is_special(o, x, y) ? 2 : 34;
        exp_q.push_back(m);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        for (int c = 1; c <= lat; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (c == lat && flush_at_done) flush = 1'b1;
            @(negedge clk);
            chk($sformatf("%s_stall_c%0d", nm, c), 32'(stall), 32'(c < lat));
            chk($sformatf("%s_done_c%0d", nm, c), 32'(done), 32'(c == lat));
            if (c == lat) chk({nm, "_result"}, result, lit);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; a = '0; b = '0;
        cmp_en = 1'b0; exp_result = '0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", result, 32'd0);
        @(posedge clk);
        #1;

        // Multiply family
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul", 1'b0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh", 1'b0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu", 1'b0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, "mulhsu", 1'b0);
        // Divide family
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div", 1'b0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem", 1'b0);
        run_op(3'd5, 32'd100, 32'd7, 32'd14, "divu", 1'b0);
        run_op(3'd7, 32'd100, 32'd7, 32'd2, "remu", 1'b0);
        // Special fast path
        run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu_by0", 1'b0);
        run_op(3'd6, 32'd5, 32'd0, 32'd5, "rem_by0", 1'b0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf", 1'b0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_ovf", 1'b0);
        // Flush during DONE has no effect
        run_op(3'd0, 32'd3, 32'd5, 32'd15, "mul_flushdone", 1'b1);

        // Flush in IDLE: stall drops in the same cycle, op not accepted
        op = 3'd0; a = 32'd9; b = 32'd9; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("flush_idle_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_idle_after_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;

        // Flush in RUN at counter 10 (cycle 12)
        op = 3'd0; a = 32'd5; b = 32'd6; start = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            @(negedge clk);
            chk($sformatf("flush_run_stall_c%0d", c), 32'(stall), 32'd1);
        end
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_run_stall_flushcyc", 32'(stall), 32'd1);
        chk("flush_run_done_flushcyc", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("flush_run_stall_after", 32'(stall), 32'd0);
        chk("flush_run_done_after", 32'(done), 32'd0);
        chk("flush_run_result_kept", result, 32'd15);
        repeat (40) @(posedge clk);
        #1;

        // Back-to-back ops
        run_op(3'd0, 32'd3, 32'd4, 32'd12, "b2b_mul", 1'b0);
        run_op(3'd5, 32'd9, 32'd3, 32'd3, "b2b_divu", 1'b0);

        // Reset at counter 20 (cycle 22)
        op = 3'd5; a = 32'd1000; b = 32'd7; start = 1'b1;
        repeat (21) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        exp_result = '0;
        exp_q.delete();
        @(negedge clk);
        chk("rst_mid_stall", 32'(stall), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_result", result, 32'd0);
        @(posedge clk);
        #1;

        // Recovery after reset
        run_op(3'd7, 32'd1000, 32'd7, 32'd6, "remu_after_rst", 1'b0);

        repeat (3) @(posedge clk);
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
